lsu_mem_ctrl: RTL and testbench

Load/store controller that sits between the single-cycle core's execute stage and `Data_Memory`, acting as the initiator on the `MemRead`/`MemWrite`/`address`/`write_data`/`read_data` interface. It accepts byte, halfword and word load/store requests from the core over a valid/ready handshake and issues only word-aligned accesses to memory. Sub-word stores use a read-modify-write sequence. Sub-word loads are returned sign- or zero-extended.

---
 rtl/lsu_mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between the core execute stage and
// Data_Memory. Accepts byte/half/word requests over valid/ready, issues only
// word-aligned memory accesses, performs read-modify-write for sub-word
// stores, and returns sign/zero-extended load data.
// Optional feature: define LSU_RANGE_CHECK_EN to reject addresses above
// MEM_BYTES-1 with resp_err instead of passing them to memory.
module lsu_mem_ctrl #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;

  logic        req_err;
  logic        accept;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign accept = (state_q == IDLE) && req_valid && !rst;

`ifdef LSU_RANGE_CHECK_EN
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 1);
`endif

  // Classify the incoming request: illegal size, misalignment, optional range.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b11:   req_err = 1'b1;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      default: req_err = 1'b0;
    endcase
`ifdef LSU_RANGE_CHECK_EN
    if (req_addr > ADDR_MAX) req_err = 1'b1;
`endif
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture request fields at acceptance and the memory word at the end of RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= req_err;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == RD) word_q <= read_data;
    end
  end

  // Store data: replace the addressed lane of the captured word, or use the
  // full store word for sw.
  always_comb begin
    merged_word = word_q;
    case (size_q)
      2'b00:   merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged_word = wdata_q;
    endcase
  end

  // Load data: little-endian lane select followed by sign/zero extension.
  always_comb begin
    byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
    half_sel = word_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_data = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = word_q;
    endcase
  end

  // Next-state and output decode; everything is forced quiet while rst is high.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                  state_d = RESP;
          else if (!req_we)             state_d = RD;
          else if (req_size == 2'b10)   state_d = WR;
          else                          state_d = RD;
        end
      end
      RD: begin
        MemRead = 1'b1;
        address = {addr_q[31:2], 2'b00};
        state_d = we_q ? WR : RESP;
      end
      WR: begin
        MemWrite   = 1'b1;
        address    = {addr_q[31:2], 2'b00};
        write_data = merged_word;
        state_d    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'd0 : load_data;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d    = IDLE;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = 32'd0;
      resp_err   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      address    = 32'd0;
      write_data = 32'd0;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a small word memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:15];

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.MEM_BYTES(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  assign read_data = (address < 32'd64) ? mem[address[5:2]] : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (MemWrite && address < 32'd64) mem[address[5:2]] <= write_data;
  end

  // Issue one request and observe it until resp_valid (lat = cycles after E0).
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] rdata,
                        output int nrd, output int nwr, output logic [31:0] raddr,
                        output logic [31:0] waddr, output logic [31:0] wdat,
                        output logic both);
    lat = -1; err = 1'b0; rdata = 32'd0; nrd = 0; nwr = 0;
    raddr = 32'd0; waddr = 32'd0; wdat = 32'd0; both = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (MemRead && MemWrite) both = 1'b1;
      if (MemRead)  begin nrd++; raddr = address; end
      if (MemWrite) begin nwr++; waddr = address; wdat = write_data; end
      if (resp_valid) begin
        lat = k; err = resp_err; rdata = resp_rdata;
        break;
      end
    end
    $display("req we=%0b size=%0d uns=%0b addr=%h wdata=%h -> lat=%0d err=%0b rdata=%h",
             we, size, uns, addr, wdata, lat, err, rdata);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h8; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0 || MemRead !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL reset_hold: ready=%b rd=%b rv=%b required 0 0 0", req_ready, MemRead, resp_valid);
    else n_pass++;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || MemRead !== 1'b0 || MemWrite !== 1'b0 || resp_valid !== 1'b0 ||
        address !== 32'd0 || write_data !== 32'd0 || resp_rdata !== 32'd0 || resp_err !== 1'b0)
      $display("FAIL reset_release: ready=%b rd=%b wr=%b rv=%b addr=%h required ready=1 others 0",
               req_ready, MemRead, MemWrite, resp_valid, address);
    else n_pass++;
    $display("reset: ready=%b", req_ready);
  endtask

  task automatic test_word;
    int lat, nrd, nwr; logic err, both; logic [31:0] rd, ra, wa, wd;
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_1234, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || nwr !== 1 || nrd !== 0 || wa !== 32'h8 || wd !== 32'h1234 || rd !== 32'd0)
      $display("FAIL sw_word: lat=%0d err=%b nwr=%0d nrd=%0d addr=%h data=%h required 2 0 1 0 00000008 00001234",
               lat, err, nwr, nrd, wa, wd);
    else n_pass++;
    do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 2 || err !== 1'b0 || rd !== 32'h0000_1234 || nrd !== 1 || nwr !== 0 || ra !== 32'h8)
      $display("FAIL lw_word: lat=%0d err=%b rdata=%h nrd=%0d required 2 0 00001234 1", lat, err, rd, nrd);
    else n_pass++;
  endtask

  task automatic test_subword_store;
    int lat, nrd, nwr; logic err, both; logic [31:0] rd, ra, wa, wd;
    mem[4] = 32'h1122_3344;
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AB, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || nrd !== 1 || nwr !== 1 || ra !== 32'h10 || wa !== 32'h10 ||
        wd !== 32'hAB22_3344 || both !== 1'b0)
      $display("FAIL sb_rmw: lat=%0d nrd=%0d nwr=%0d wa=%h wd=%h required 3 1 1 00000010 ab223344",
               lat, nrd, nwr, wa, wd);
    else n_pass++;
    do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 3 || err !== 1'b0 || nwr !== 1 || wd !== 32'hAB22_BEEF)
      $display("FAIL sh_rmw: lat=%0d err=%b wd=%h required 3 0 ab22beef", lat, err, wd);
    else n_pass++;
    n_checks++;
    if (mem[4] !== 32'hAB22_BEEF)
      $display("FAIL sh_mem: mem=%h required ab22beef", mem[4]);
    else n_pass++;
  endtask

  task automatic test_loads;
    int lat, nrd, nwr; logic err, both; logic [31:0] rd, ra, wa, wd;
    mem[8] = 32'h80F0_7F01;
    do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (rd !== 32'hFFFF_FF80 || lat !== 2 || ra !== 32'h20)
      $display("FAIL lb: rdata=%h lat=%0d addr=%h required ffffff80 2 00000020", rd, lat, ra);
    else n_pass++;
    do_req(1'b0, 2'b00, 1'b1, 32'h23, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (rd !== 32'h0000_0080 || lat !== 2)
      $display("FAIL lbu: rdata=%h lat=%0d required 00000080 2", rd, lat);
    else n_pass++;
    do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (rd !== 32'hFFFF_80F0 || lat !== 2)
      $display("FAIL lh: rdata=%h lat=%0d required ffff80f0 2", rd, lat);
    else n_pass++;
    do_req(1'b0, 2'b01, 1'b1, 32'h20, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (rd !== 32'h0000_7F01 || lat !== 2)
      $display("FAIL lhu: rdata=%h lat=%0d required 00007f01 2", rd, lat);
    else n_pass++;
    do_req(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (rd !== 32'h0000_007F)
      $display("FAIL lb_pos: rdata=%h required 0000007f", rd);
    else n_pass++;
  endtask

  task automatic test_errors;
    int lat, nrd, nwr; logic err, both; logic [31:0] rd, ra, wa, wd;
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0 || rd !== 32'd0)
      $display("FAIL err_lw_mis: lat=%0d err=%b nrd=%0d nwr=%0d required 1 1 0 0", lat, err, nrd, nwr);
    else n_pass++;
    do_req(1'b1, 2'b01, 1'b0, 32'h21, 32'h5555, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0)
      $display("FAIL err_sh_mis: lat=%0d err=%b nrd=%0d nwr=%0d required 1 1 0 0", lat, err, nrd, nwr);
    else n_pass++;
    do_req(1'b0, 2'b11, 1'b0, 32'h0, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
    if (lat !== 1 || err !== 1'b1 || nrd !== 0 || nwr !== 0)
      $display("FAIL err_size: lat=%0d err=%b nrd=%0d nwr=%0d required 1 1 0 0", lat, err, nrd, nwr);
    else n_pass++;
  endtask

  task automatic test_range;
    int lat, nrd, nwr; logic err, both; logic [31:0] rd, ra, wa, wd;
    do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, lat, err, rd, nrd, nwr, ra, wa, wd, both);
    n_checks++;
`ifdef LSU_RANGE_CHECK_EN
    if (lat !== 1 || err !== 1'b1 || nrd !== 0)
      $display("FAIL range_lw40: lat=%0d err=%b nrd=%0d required 1 1 0", lat, err, nrd);
    else n_pass++;
`else
    if (lat !== 2 || err !== 1'b0 || nrd !== 1 || ra !== 32'h40)
      $display("FAIL range_lw40: lat=%0d err=%b nrd=%0d addr=%h required 2 0 1 00000040", lat, err, nrd, ra);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    mem[9] = 32'h5566_7788;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h24; req_wdata = 32'h0000_00CC;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (MemRead !== 1'b1)
      $display("FAIL rstmid_rd: MemRead=%b required 1", MemRead);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (MemWrite !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL rstmid_wr: MemWrite=%b resp_valid=%b required 0 0", MemWrite, resp_valid);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1)
      $display("FAIL rstmid_ready: req_ready=%b required 1", req_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid || MemWrite || MemRead) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad !== 0 || mem[9] !== 32'h5566_7788)
      $display("FAIL rstmid_quiet: stray=%0d mem=%h required 0 55667788", bad, mem[9]);
    else n_pass++;
    $display("reset mid-access: mem[0x24]=%h", mem[9]);
  endtask

  task automatic test_back_to_back;
    int acc = 0, nresp = 0, rbad = 0, ready_bad = 0, both = 0;
    mem[2] = 32'h0000_1234;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'd0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (MemRead && MemWrite) both++;
      if ((MemRead || resp_valid) && req_ready) ready_bad++;
      if (resp_valid) begin
        nresp++;
        if (resp_rdata !== 32'h0000_1234) rbad++;
      end
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 3) begin
          @(posedge clk);
          #1 req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (acc !== 3 || nresp !== 3 || rbad !== 0)
      $display("FAIL b2b_count: acc=%0d resp=%0d badrdata=%0d required 3 3 0", acc, nresp, rbad);
    else n_pass++;
    n_checks++;
    if (ready_bad !== 0 || both !== 0)
      $display("FAIL b2b_ready: ready_in_busy=%0d both_strobes=%0d required 0 0", ready_bad, both);
    else n_pass++;
    $display("back-to-back: accepted=%0d responses=%0d", acc, nresp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_errors();
    test_range();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
